// File: rtl/wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// wb_port_arbiter
//
// Shares the single register-file write port between the in-order writeback
// stage and long-latency result producers (divider, late loads). Late results
// wait in a small FIFO. Writeback normally wins. A starvation counter
// force-grants the FIFO head after STARVE_MAX consecutive lost arbitrations.
//
// Optional feature macro: WB_ARB_BYPASS_EN
//   When defined, a late result goes straight to the write port if the FIFO
//   is empty and no writeback write wins that cycle. Such a result is not
//   enqueued and does not touch pend_mask.
//
// Handshakes:
//   lu_valid/lu_ready transfer one late result in any cycle where both are
//   high. lu_ready does not depend on lu_valid. pipe_valid is a request that
//   the writeback stage must hold while pipe_stall is high.
//
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   pipe_valid/rd/data   writeback write request
//   pipe_stall           writeback must hold its request (combinational)
//   lu_valid/rd/data     late-unit result offer
//   lu_ready             late result accepted this cycle (combinational)
//   reg_w_enabled/addr/data  registered register-file write
//   pend_mask            bit r set while a queued entry targets xr
//   fifo_count           current FIFO occupancy (0..DEPTH)
// -----------------------------------------------------------------------------
module wb_port_arbiter #(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     pipe_valid,
  input  logic [4:0]               pipe_rd,
  input  logic [31:0]              pipe_data,
  output logic                     pipe_stall,
  input  logic                     lu_valid,
  input  logic [4:0]               lu_rd,
  input  logic [31:0]              lu_data,
  output logic                     lu_ready,
  output logic                     reg_w_enabled,
  output logic [4:0]               reg_w_addr,
  output logic [31:0]              reg_w_data,
  output logic [31:0]              pend_mask,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [SW-1:0] STARVE_C = SW'(STARVE_MAX);

  logic [4:0]    rd_mem   [DEPTH];
  logic [31:0]   data_mem [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          w_en_q, w_en_d;
  logic [4:0]    w_addr_q, w_addr_d;
  logic [31:0]   w_data_q, w_data_d;

  logic fifo_empty, fifo_full, force_grant;
  logic pipe_win, fifo_win, push, bypass;

  assign fifo_empty  = (count_q == '0);
  assign fifo_full   = (count_q == DEPTH_C);
  assign force_grant = !fifo_empty && (starve_q == STARVE_C);
  // A writeback request to x0 is never a real write, so it never blocks the FIFO.
  assign pipe_win    = !force_grant && pipe_valid && (pipe_rd != 5'd0);
  assign fifo_win    = !fifo_empty && !pipe_win;

  assign pipe_stall  = force_grant && pipe_valid;
  // Full means not ready, even if the head pops this cycle.
  assign lu_ready    = rstn && !fifo_full;

`ifdef WB_ARB_BYPASS_EN
  assign bypass = fifo_empty && !pipe_win && lu_valid && (lu_rd != 5'd0);
`else
  assign bypass = 1'b0;
`endif

  // x0 results complete the handshake but are dropped.
  assign push = lu_valid && lu_ready && (lu_rd != 5'd0) && !bypass;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    starve_d = starve_q;
    w_en_d   = 1'b0;
    w_addr_d = 5'd0;
    w_data_d = 32'd0;

    if (push)     wr_ptr_d = wr_ptr_q + PW'(1);
    if (fifo_win) rd_ptr_d = rd_ptr_q + PW'(1);

    case ({push, fifo_win})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (fifo_empty || fifo_win) begin
      starve_d = '0;
    end else if (pipe_win && (starve_q != STARVE_C)) begin
      starve_d = starve_q + SW'(1);
    end

    if (pipe_win) begin
      w_en_d   = 1'b1;
      w_addr_d = pipe_rd;
      w_data_d = pipe_data;
    end else if (fifo_win) begin
      w_en_d   = 1'b1;
      w_addr_d = rd_mem[rd_ptr_q];
      w_data_d = data_mem[rd_ptr_q];
    end else if (bypass) begin
      w_en_d   = 1'b1;
      w_addr_d = lu_rd;
      w_data_d = lu_data;
    end
  end

  // Walk the live window rd_ptr .. rd_ptr+count-1; duplicates simply OR together.
  always_comb begin
    logic [PW-1:0] idx;
    pend_mask = 32'd0;
    idx       = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (CW'(k) < count_q) begin
        idx = rd_ptr_q + PW'(k);
        pend_mask[rd_mem[idx]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
      w_en_q   <= 1'b0;
      w_addr_q <= 5'd0;
      w_data_q <= 32'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      w_en_q   <= w_en_d;
      w_addr_q <= w_addr_d;
      w_data_q <= w_data_d;
    end
  end

  // Payload storage needs no reset; only entries inside the count window are read.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[wr_ptr_q]   <= lu_rd;
      data_mem[wr_ptr_q] <= lu_data;
    end
  end

  assign reg_w_enabled = w_en_q;
  assign reg_w_addr    = w_addr_q;
  assign reg_w_data    = w_data_q;
  assign fifo_count    = count_q;

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single architectural register-file write port between two requesters:
  - the in-order writeback stage;
  - long-latency result producers (divider, late loads).
- Late results are queued in a small FIFO.
- The writeback stage normally has priority; a starvation counter forces the FIFO to drain.
- The block exports a pending-destination mask so issue logic can block RAW/WAW hazards on queued results.

Parameters:
- DEPTH, 4, late-result FIFO entries (power of two, ≥2).
- STARVE_MAX, 8, consecutive lost arbitrations by a non-empty FIFO before it is force-granted (≥1).

Ports:
- clk  input  1  clock
- rstn  input  1  asynchronous active-low reset
- pipe_valid  input  1  writeback stage has a register write this cycle
- pipe_rd  input  5  writeback destination
- pipe_data  input  32  writeback value
- pipe_stall  output  1  writeback stage must hold its request this cycle (combinational)
- lu_valid  input  1  late unit offers a result
- lu_rd  input  5  late result destination
- lu_data  input  32  late result value
- lu_ready  output  1  FIFO accepts the late result this cycle (combinational)
- reg_w_enabled  output  1  registered write enable to the register file
- reg_w_addr  output  5  registered write address
- reg_w_data  output  32  registered write data
- pend_mask  output  32  bit r set while a queued FIFO entry targets xr
- fifo_count  output  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset: one clk, asynchronous active-low rstn. While rstn=0:
  - FIFO is emptied (rd/wr pointers and count = 0) and the starvation counter is cleared.
  - reg_w_enabled=0, reg_w_addr=0, reg_w_data=0.
  - pend_mask=0, lu_ready=0, pipe_stall=0.
  - Reset mid-operation discards all queued results.
- Write latency: the winner's write appears on reg_w_* one clk after the grant cycle.
  - Output register holds enable=0, addr=0, data=0 when nothing wins.
- rd==0 filtering:
  - pipe request with pipe_rd=0 never wins a write.
  - lu handshake with lu_rd=0 is consumed (lu_ready honoured) but not enqueued.
- FIFO enqueue: on lu_valid && lu_ready && lu_rd!=0, push {rd,data}.
  - lu_ready = rstn && count<DEPTH. No pass-through when full, even if dequeuing the same cycle.
- Arbitration, evaluated each cycle:
  - force = FIFO non-empty && starve_cnt==STARVE_MAX.
  - force=1: FIFO head wins; pipe_stall = pipe_valid.
  - force=0, pipe_valid && pipe_rd!=0: pipe wins; pipe_stall=0.
  - Otherwise: FIFO head wins if non-empty, else no write.
- Dequeue: the head pops in the cycle it wins. Simultaneous push and pop keeps count unchanged and is legal when full-before-pop is false.
- Starvation counter:
  - Increments, saturating at STARVE_MAX, each cycle the FIFO is non-empty and the pipe wins.
  - Clears on any FIFO grant or when the FIFO is empty.
- pend_mask: OR of one-hot(rd) over valid FIFO entries, derived from registered state.
  - Deasserts the cycle after the last entry for that rd pops; the write is visible on reg_w_* that same cycle.
  - Duplicate rd entries keep the bit until all of them pop.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH.

Optional Feature:
- Macro: WB_ARB_BYPASS_EN.
- With the macro: when the FIFO is empty, no pipe write wins, and lu_valid && lu_rd!=0, the late result is written directly to reg_w_* next cycle without enqueue.
  - lu_ready=1 in this case.
  - pend_mask is unaffected.
- Without the macro: every late result is enqueued first; minimum late-result latency is 2 clk (push cycle, grant cycle).

Test Plan:
- Reset then idle: rstn low for 3 clk with lu_valid=1 -> lu_ready=0, reg_w_enabled=0, pend_mask=0, fifo_count=0; after release the FIFO is still empty.
- Pipe only: pipe_valid=1, rd=5, data=0x12345678 -> next clk reg_w_enabled=1, addr=5, data=0x12345678. Then rd=0 -> reg_w_enabled=0.
- Late result, no contention (macro off): lu rd=7, data=0xA5A5A5A5 for one cycle -> pend_mask[7]=1 and fifo_count=1 next cycle. Write appears 2 clk after the push. pend_mask[7]=0 in the same cycle reg_w_enabled=1.
- Full backpressure: pipe_valid=1 continuously with rd=1, push 5 results rd=10..14 -> first 4 accepted, lu_ready=0 on the 5th, fifo_count=4, pend_mask=0x00007C00 minus bit 14.
- Starvation: DEPTH=4, STARVE_MAX=8, FIFO non-empty, pipe_valid=1 continuously -> pipe wins 8 cycles, 9th cycle pipe_stall=1 and the FIFO head is written; counter clears, pattern repeats.
- Bypass (macro on): FIFO empty, pipe_valid=0, lu rd=3, data=0x1 -> reg_w_* written next clk, fifo_count stays 0, pend_mask stays 0.
